board_writer: RTL and testbench

//  Write side of the board-state RAM that the VGA path reads (re/raddr, 16-bit tiles).

---
 rtl/vga_pkg.sv | 19 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/board_writer.sv | 116 +++++++++++
 tb/tb_board_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA board-state path.
// Tile update bundle and board-writer FSM states.
package vga_pkg;

  localparam int TILE_W  = 16;
  localparam int TADDR_W = 10;

  typedef struct packed {
    logic [TADDR_W-1:0] addr;
    logic [TILE_W-1:0]  data;
  } tile_upd_t;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_DRAIN,
    BW_DONE
  } bw_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and a separate count.
// Flush empties it on the next edge and discards any push that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  assign dout  = mem[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      rp    <= wp;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; only entries behind the pointers are read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/board_writer.sv
// Queues tile/score updates and commits them to board RAM port B
// only during vertical blanking, so every frame is tear-free.
module board_writer
  import vga_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_TILES = 768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [TADDR_W-1:0] upd_addr,
  input  logic [TILE_W-1:0]  upd_data,
  input  logic               score_valid,
  input  logic [7:0]         score_in,
  input  logic               vblank,
  input  logic               flush,
  output logic               we,
  output logic [TADDR_W-1:0] waddr,
  output logic [TILE_W-1:0]  wdata,
  output logic [7:0]         score_out,
  output logic               frame_commit,
  output logic               addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [TADDR_W:0] ADDR_LIM = (TADDR_W+1)'(NUM_TILES);

  bw_state_t state, nxt;
  tile_upd_t din, head;
  logic [AW:0] cnt_unused;
  logic [7:0]  score_pending;
  logic        full, empty, accept, addr_ok, push, pop;
  logic        vblank_d, vrise, commit_n, load_score;

  assign upd_ready = !full;
  assign accept    = upd_valid && upd_ready;
  assign addr_ok   = {1'b0, upd_addr} < ADDR_LIM;
  assign push      = accept && addr_ok;
  assign vrise     = vblank && !vblank_d;
  assign din       = '{addr: upd_addr, data: upd_data};

  sync_fifo #(
    .WIDTH($bits(tile_upd_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(cnt_unused)
  );

  always_comb begin
    nxt        = state;
    pop        = 1'b0;
    commit_n   = 1'b0;
    load_score = 1'b0;
    unique case (state)
      BW_IDLE: begin
        if (vrise) begin
          nxt        = BW_DRAIN;
          load_score = 1'b1;
        end
      end
      // Blanking ending early leaves the rest for the next frame.
      BW_DRAIN: begin
        if (!vblank) begin
          nxt = BW_IDLE;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          nxt      = BW_DONE;
          commit_n = 1'b1;
        end
      end
      BW_DONE: begin
        if (!vblank) nxt = BW_IDLE;
      end
      default: nxt = BW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= BW_IDLE;
      vblank_d      <= 1'b0;
      score_pending <= '0;
      score_out     <= '0;
      we            <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      frame_commit  <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      state        <= nxt;
      vblank_d     <= vblank;
      we           <= pop;
      frame_commit <= commit_n;
      if (score_valid) score_pending <= score_in;
      if (load_score)  score_out     <= score_pending;
      if (pop) begin
        waddr <= head.addr;
        wdata <= head.data;
      end
      if (accept && !addr_ok) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer: queued writes must reach
// the RAM port in order, only inside blanking.
module tb_board_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [9:0]  upd_addr = '0;
  logic [15:0] upd_data = '0;
  logic        score_valid = 1'b0;
  logic [7:0]  score_in = '0;
  logic        vblank = 1'b0;
  logic        flush = 1'b0;
  logic        we;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic [7:0]  score_out;
  logic        frame_commit;
  logic        addr_err;

  int errs = 0;
  int checks = 0;
  int wr_cnt = 0;
  int commit_cnt = 0;
  logic [25:0] exp_q [$];

  board_writer dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_addr    (upd_addr),
    .upd_data    (upd_data),
    .score_valid (score_valid),
    .score_in    (score_in),
    .vblank      (vblank),
    .flush       (flush),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .score_out   (score_out),
    .frame_commit(frame_commit),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_commit) commit_cnt++;
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", {6'b0, waddr, wdata}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_data", {6'b0, waddr, wdata}, {6'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] a, input logic [15:0] d);
    int n;
    n = 0;
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_data  = d;
    forever begin
      @(negedge clk);
      if (upd_ready) break;
      n++;
      if (n > 50) break;
    end
    chk("push_ready", 32'(n <= 50), 1);
    if (n <= 50 && a < 10'd768) exp_q.push_back({a, d});
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_commit(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      if (frame_commit) break;
      n++;
    end
    chk("commit_seen", 32'(n < max), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, w0, c0;

    #2;
    chk("rst_we", 32'(we), 0);
    chk("rst_ready", 32'(upd_ready), 1);
    chk("rst_outs", {waddr, wdata, score_out, frame_commit, addr_err}, 0);
    tick();
    reset = 1'b1;
    tick();

    // Three updates held until blanking, then written in cycles 2..4.
    w0 = wr_cnt;
    push(10'd5, 16'hAAAA);
    push(10'd6, 16'hBBBB);
    push(10'd7, 16'hCCCC);
    tick();
    chk("no_wr_active", 32'(wr_cnt - w0), 0);
    vblank = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t2_we_c%0d", k), 32'(we), 32'(k >= 2 && k <= 4));
      chk($sformatf("t2_fc_c%0d", k), 32'(frame_commit), 32'(k == 5));
    end
    tick();
    vblank = 1'b0;
    tick();
    tick();

    // Fill to full; the 17th is taken once draining frees a slot.
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) push(10'(32 + i), 16'(16'h1000 + i));
    @(negedge clk);
    chk("full_ready", 32'(upd_ready), 0);
    tick();
    upd_valid = 1'b1;
    upd_addr  = 10'd100;
    upd_data  = 16'h1717;
    vblank    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t3_ready_c%0d", k), 32'(upd_ready), 32'(k == 2));
    end
    exp_q.push_back({10'd100, 16'h1717});
    tick();
    upd_valid = 1'b0;
    wait_commit(40, n);
    chk("t3_writes", 32'(wr_cnt - w0), 17);
    tick();
    vblank = 1'b0;
    tick();
    tick();

    // Blanking too short: 3 written, rest carried to next frame.
    w0 = wr_cnt;
    c0 = commit_cnt;
    for (int i = 0; i < 10; i++) push(10'(200 + i), 16'(16'h4000 + i));
    vblank = 1'b1;
    repeat (4) tick();
    vblank = 1'b0;
    repeat (6) tick();
    chk("t4_partial", 32'(wr_cnt - w0), 3);
    chk("t4_no_commit", 32'(commit_cnt - c0), 0);
    vblank = 1'b1;
    wait_commit(20, n);
    chk("t4_total", 32'(wr_cnt - w0), 10);
    chk("t4_q_empty", 32'(exp_q.size()), 0);
    tick();
    vblank = 1'b0;
    tick();
    tick();

    // Out-of-range address: accepted, flagged, never written.
    chk("err_before", 32'(addr_err), 0);
    w0 = wr_cnt;
    push(10'h3FF, 16'hDEAD);
    @(negedge clk);
    chk("err_set", 32'(addr_err), 1);
    tick();
    push(10'd8, 16'h8888);
    vblank = 1'b1;
    wait_commit(20, n);
    chk("t5_writes", 32'(wr_cnt - w0), 1);
    chk("err_sticky", 32'(addr_err), 1);
    tick();
    vblank = 1'b0;
    tick();
    tick();

    // Flush discards queued entries; an empty drain commits in cycle 2.
    w0 = wr_cnt;
    push(10'd1, 16'h0101);
    push(10'd2, 16'h0202);
    flush = 1'b1;
    upd_valid = 1'b1;
    upd_addr  = 10'd3;
    upd_data  = 16'h0303;
    tick();
    flush = 1'b0;
    upd_valid = 1'b0;
    exp_q.delete();
    vblank = 1'b1;
    wait_commit(10, n);
    chk("flush_commit_cyc", 32'(n), 2);
    chk("flush_no_wr", 32'(wr_cnt - w0), 0);
    tick();
    vblank = 1'b0;
    tick();
    tick();

    // Score latched only on vblank rise; then reset mid-drain.
    score_valid = 1'b1;
    score_in    = 8'h12;
    tick();
    score_in    = 8'h34;
    tick();
    score_valid = 1'b0;
    for (int i = 0; i < 4; i++) push(10'(300 + i), 16'(16'h5000 + i));
    @(negedge clk);
    chk("score_hold", 32'(score_out), 0);
    tick();
    vblank = 1'b1;
    @(negedge clk);
    chk("score_c0", 32'(score_out), 0);
    @(negedge clk);
    chk("score_c1", 32'(score_out), 8'h34);
    @(negedge clk);
    chk("drain_we", 32'(we), 1);
    #2;
    reset = 1'b0;
    vblank = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_outs", {waddr, wdata, score_out, frame_commit, addr_err}, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(upd_ready), 1);
    tick();
    w0 = wr_cnt;
    vblank = 1'b1;
    wait_commit(10, n);
    chk("post_rst_commit", 32'(n), 2);
    chk("post_rst_empty", 32'(wr_cnt - w0), 0);
    tick();
    vblank = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
